// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST result serializer: FSM state
// encoding, default frame header and a constant-foldable clog2 for sizing.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bist_ser_state_t;

  localparam int         HEADER_BITS       = 8;
  localparam logic [7:0] BIST_FRAME_HEADER = 8'hA5;

  // Smallest r with 2**r >= value; bounded loop so it also elaborates in synthesis.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bist_frame_shreg.sv
// Parallel-load, MSB-first shift register holding one serial frame.
// A load wins over a shift; vacated LSBs fill with zeros.
module bist_frame_shreg #(
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/bist_result_serializer.sv
// Captures per-memory BIST result bytes and shifts them out as one framed,
// MSB-first bitstream. Define BIST_RESULT_PARITY_EN to append even parity per byte.
module bist_result_serializer
  import bist_pkg::*;
#(
  parameter int         NUM_MEMS     = 4,
  parameter int         RESULT_WIDTH = 8,
  parameter logic [7:0] FRAME_HEADER = BIST_FRAME_HEADER
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             bistDone_i,
  input  logic [NUM_MEMS*RESULT_WIDTH-1:0] memResult_i,
  input  logic                             shiftEn_i,
  input  logic                             clear_i,
  output logic                             serialOut_o,
  output logic                             frameValid_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             overrun_o
);

`ifdef BIST_RESULT_PARITY_EN
  localparam int SLOT_BITS = RESULT_WIDTH + 1;
`else
  localparam int SLOT_BITS = RESULT_WIDTH;
`endif
  localparam int FRAME_BITS = HEADER_BITS + NUM_MEMS * SLOT_BITS;
  localparam int CNT_W      = clog2(FRAME_BITS + 1);

  bist_ser_state_t        state;
  logic [CNT_W-1:0]       cnt;
  logic                   overrun;
  logic [FRAME_BITS-1:0]  frame;
  logic                   capture;
  logic                   advance;
  logic                   last_bit;
  logic                   shreg_msb;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    frame = '0;
    frame[FRAME_BITS-1 -: HEADER_BITS] = FRAME_HEADER;
    for (int m = 0; m < NUM_MEMS; m++) begin
      frame[FRAME_BITS-HEADER_BITS-1-m*SLOT_BITS -: RESULT_WIDTH] =
        memResult_i[m*RESULT_WIDTH +: RESULT_WIDTH];
`ifdef BIST_RESULT_PARITY_EN
      frame[FRAME_BITS-HEADER_BITS-1-m*SLOT_BITS-RESULT_WIDTH] =
        ^memResult_i[m*RESULT_WIDTH +: RESULT_WIDTH];
`endif
    end
  end

  // clear_i masks both capture and shifting so the frame register never
  // moves in a cycle that aborts.
  assign capture  = (state == IDLE)  && bistDone_i && !clear_i;
  assign advance  = (state == SHIFT) && shiftEn_i  && !clear_i;
  assign last_bit = (cnt == CNT_W'(FRAME_BITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      overrun <= 1'b0;
    end else if (clear_i) begin
      state   <= IDLE;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      if (bistDone_i && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (bistDone_i) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (shiftEn_i) begin
            cnt <= cnt + CNT_W'(1);
            if (last_bit) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  bist_frame_shreg #(
    .WIDTH (FRAME_BITS)
  ) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .load      (capture),
    .load_data (frame),
    .shift     (advance),
    .msb       (shreg_msb)
  );

  // All outputs decode registered state only.
  assign frameValid_o = (state == SHIFT);
  assign serialOut_o  = frameValid_o & shreg_msb;
  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE);
  assign overrun_o    = overrun;

endmodule

// File: tb/tb_bist_result_serializer.sv
// Directed self-checking bench for bist_result_serializer: basic frame, stall,
// overrun, abort, asynchronous reset, and the parity build when enabled.
module tb_bist_result_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        bistDone_i;
  logic [31:0] memResult_i;
  logic        shiftEn_i;
  logic        clear_i;
  logic        serialOut_o;
  logic        frameValid_o;
  logic        busy_o;
  logic        done_o;
  logic        overrun_o;

  int tests_run    = 0;
  int tests_failed = 0;
  bit exp_bits[$];

  bist_result_serializer dut (
    .clk          (clk),
    .reset        (reset),
    .bistDone_i   (bistDone_i),
    .memResult_i  (memResult_i),
    .shiftEn_i    (shiftEn_i),
    .clear_i      (clear_i),
    .serialOut_o  (serialOut_o),
    .frameValid_o (frameValid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit with_parity);
    for (int k = 7; k >= 0; k--) exp_bits.push_back(b[k]);
    if (with_parity) exp_bits.push_back(^b);
  endtask

  task automatic build_exp(input logic [31:0] d);
    bit par;
`ifdef BIST_RESULT_PARITY_EN
    par = 1'b1;
`else
    par = 1'b0;
`endif
    exp_bits.delete();
    push_byte(8'hA5, 1'b0);
    for (int m = 0; m < 4; m++) push_byte(d[m*8 +: 8], par);
  endtask

  task automatic start_frame(input logic [31:0] d);
    memResult_i = d;
    bistDone_i  = 1'b1;
    tick();
    bistDone_i  = 1'b0;
    build_exp(d);
  endtask

  initial begin
    reset = 1'b1; bistDone_i = 1'b0; memResult_i = '0; shiftEn_i = 1'b0; clear_i = 1'b0;
    tick(); tick();
    check("rst_serial", serialOut_o, 0);
    check("rst_valid", frameValid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_overrun", overrun_o, 0);
    reset = 1'b0;
    tick();

    // Basic frame, shiftEn_i held high.
    start_frame(32'h4433_2211);
    check("basic_valid", frameValid_o, 1);
    shiftEn_i = 1'b1;
    for (int i = 0; i < exp_bits.size(); i++) begin
      check($sformatf("basic_bit%0d", i), serialOut_o, exp_bits[i]);
      if (i == exp_bits.size() - 1) check("basic_no_early_done", done_o, 0);
      tick();
    end
    check("basic_done", done_o, 1);
    check("basic_done_valid", frameValid_o, 0);
    tick();
    check("basic_idle_busy", busy_o, 0);
    check("basic_done_pulse", done_o, 0);
    shiftEn_i = 1'b0;

    // Stall: every bit held for one extra cycle with shiftEn_i low.
    start_frame(32'h4433_2211);
    for (int i = 0; i < exp_bits.size(); i++) begin
      check($sformatf("stall_bit%0d", i), serialOut_o, exp_bits[i]);
      shiftEn_i = 1'b0;
      tick();
      check($sformatf("stall_hold%0d", i), serialOut_o, exp_bits[i]);
      check($sformatf("stall_nodone%0d", i), done_o, 0);
      shiftEn_i = 1'b1;
      tick();
    end
    shiftEn_i = 1'b0;
    check("stall_done", done_o, 1);
    tick();

    // Overrun: second pulse with all-ones results at bit 10.
    start_frame(32'h4433_2211);
    shiftEn_i = 1'b1;
    for (int i = 0; i < exp_bits.size(); i++) begin
      check($sformatf("ovr_bit%0d", i), serialOut_o, exp_bits[i]);
      if (i == 10) begin
        memResult_i = 32'hFFFF_FFFF;
        bistDone_i  = 1'b1;
      end
      tick();
      bistDone_i = 1'b0;
    end
    check("ovr_done", done_o, 1);
    check("ovr_sticky_done", overrun_o, 1);
    shiftEn_i = 1'b0;
    tick();
    check("ovr_sticky_idle", overrun_o, 1);
    check("ovr_no_restart", busy_o, 0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("ovr_cleared", overrun_o, 0);

    // Abort: overrun set at bit 5, clear_i plus bistDone_i at bit 20.
    start_frame(32'h4433_2211);
    shiftEn_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) bistDone_i = 1'b1;
      tick();
      bistDone_i = 1'b0;
    end
    check("abort_pre_overrun", overrun_o, 1);
    check("abort_bit20", serialOut_o, exp_bits[20]);
    clear_i    = 1'b1;
    bistDone_i = 1'b1;
    tick();
    clear_i    = 1'b0;
    bistDone_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_valid", frameValid_o, 0);
    check("abort_serial", serialOut_o, 0);
    check("abort_overrun", overrun_o, 0);
    check("abort_no_done", done_o, 0);
    tick();
    check("abort_no_done2", done_o, 0);
    check("abort_stay_idle", busy_o, 0);
    shiftEn_i = 1'b0;

    // Reset asserted between edges while bit 15 (a 1) is on the pin.
    start_frame(32'h4433_2211);
    shiftEn_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) bistDone_i = 1'b1;
      tick();
      bistDone_i = 1'b0;
    end
    check("rstmid_bit15", serialOut_o, 1);
    reset = 1'b1;
    #1;
    check("rstmid_serial", serialOut_o, 0);
    check("rstmid_valid", frameValid_o, 0);
    check("rstmid_busy", busy_o, 0);
    check("rstmid_overrun", overrun_o, 0);
    tick();
    reset = 1'b0;
    shiftEn_i = 1'b0;
    tick();
    start_frame(32'h4433_2211);
    check("rstmid_new_valid", frameValid_o, 1);
    check("rstmid_new_hdr7", serialOut_o, 1);
    shiftEn_i = 1'b1;
    for (int i = 0; i < exp_bits.size(); i++) begin
      check($sformatf("rstmid_bit%0d", i), serialOut_o, exp_bits[i]);
      tick();
    end
    check("rstmid_done", done_o, 1);
    shiftEn_i = 1'b0;
    tick();

`ifdef BIST_RESULT_PARITY_EN
    // Parity bytes 00,07,03,01 give parity 0,1,0,1 at bit positions 16,25,34,43.
    start_frame(32'h0103_0700);
    shiftEn_i = 1'b1;
    for (int i = 0; i < 44; i++) begin
      case (i)
        16: check("par_mem1", serialOut_o, 0);
        25: check("par_mem2", serialOut_o, 1);
        34: check("par_mem3", serialOut_o, 0);
        43: check("par_mem4", serialOut_o, 1);
        default: check($sformatf("par_bit%0d", i), serialOut_o, exp_bits[i]);
      endcase
      if (i == 43) check("par_no_early_done", done_o, 0);
      tick();
    end
    check("par_done44", done_o, 1);
    shiftEn_i = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
